ahb_sram_slave: RTL

- AHB-lite slave with an internal word-organised SRAM array. It is the DUT that consumes the master-side signals driven through the team's AHB interface by the driver clocking block.
- Supports single transfers and bursts as back-to-back pipelined transfers, byte/halfword/word sizes, programmable wait states, and a two-cycle ERROR response.
- Used as the reference target for the AHB slave verification environment.

---
 rtl/ahb_sram_slave_if.sv | 28 ++
 rtl/ahb_sram_slave.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-lite signal bundle between a master and the SRAM slave
interface ahb_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hwdata;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-lite slave with word-organised SRAM, wait states and ERROR response
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    ahb_sram_slave_if.slave   bus
);
    localparam int                    IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);
    localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic                  hreadyout_q, hreadyout_d;
    logic                  hresp_q, hresp_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  capture;
    logic                  addr_ok;
    logic                  mem_we;
    logic                  rd_active;
    logic [3:0]            byte_en;
    logic [IDX_W-1:0]      word_idx;
    logic                  unused_sig;

    // Address phase is only looked at while this slave is driving hreadyout high
    assign capture = bus.hsel && bus.hready && bus.htrans[1] &&
                     (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2);

    // Legality of the address phase currently on the bus: range, size and alignment
    always_comb begin
        addr_ok = (bus.haddr < ADDR_LIMIT);
        case (bus.hsize)
            3'b000:  ;
            3'b001:  if (bus.haddr[0]) addr_ok = 1'b0;
            3'b010:  if (bus.haddr[1:0] != 2'b00) addr_ok = 1'b0;
            default: addr_ok = 1'b0;
        endcase
    end

    // Next-state and registered-output computation for the transfer FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all close a ready cycle and may accept a new transfer
                state_d = S_IDLE;
                if (capture) begin
                    addr_d  = bus.haddr;
                    write_d = bus.hwrite;
                    size_d  = bus.hsize;
                    if (!addr_ok) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
        endcase
        hreadyout_d = !(state_d == S_WAIT || state_d == S_ERR1);
        hresp_d     = (state_d == S_ERR1 || state_d == S_ERR2);
    end

    // FSM, latched address-phase fields and registered response outputs
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 3'b000;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign word_idx  = addr_q[IDX_W+1:2];
    assign mem_we    = (state_q == S_DATA) && write_q;
    assign rd_active = (state_q == S_WAIT || state_q == S_DATA) && !write_q;

    // Little-endian byte lanes touched by the latched size/offset
    always_comb begin
        case (size_q)
            3'b000:  byte_en = 4'b0001 << addr_q[1:0];
            3'b001:  byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    end

    // SRAM write port: commits on the edge that ends the write data phase; contents survive reset
    always_ff @(posedge hclk) begin
        if (mem_we && !hreset) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
        end
    end

    assign bus.hrdata    = rd_active ? mem[word_idx] : '0;
    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;

    assign unused_sig = ^{bus.hburst, bus.hprot, addr_q};
endmodule
